// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 8-bit processor: fetches over a req/valid
// handshake, decodes, and drives register file, ALU op and immediate mux.
module unidade_controle #(
  parameter int unsigned LARGURA = 8,
  parameter logic [LARGURA-1:0] PC_INICIAL = 8'h00
) (
  input  logic               Clock,
  input  logic               Resetn,
  output logic               MemReq,
  output logic [LARGURA-1:0] MemEndereco,
  input  logic               MemValido,
  input  logic [LARGURA-1:0] MemDado,
  output logic               RegEscrita,
  output logic [1:0]         RegDestino,
  output logic [1:0]         RegFonteA,
  output logic [1:0]         RegFonteB,
  output logic [2:0]         AluOp,
  output logic               SelImediato,
  output logic [LARGURA-1:0] Imediato,
  output logic [LARGURA-1:0] PC,
  output logic               Parado
);

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    IMEDIATO   = 3'd3,
    EXECUTA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [LARGURA-1:0] UM = {{(LARGURA-1){1'b0}}, 1'b1};

  estado_t            estado_r, estado_s;
  logic [LARGURA-1:0] ir_r, ir_s;
  logic [LARGURA-1:0] pc_r, pc_s;
  logic [LARGURA-1:0] imm_r, imm_s;

  logic               memreq_r, memreq_s;
  logic [LARGURA-1:0] memend_r, memend_s;
  logic               regescrita_r, regescrita_s;
  logic [2:0]         aluop_r, aluop_s;
  logic               selimm_r, selimm_s;
  logic               parado_r, parado_s;

  logic [2:0] opcode_s;
  logic [2:0] opcode_nx_s;
  assign opcode_s    = ir_r[7:5];
  assign opcode_nx_s = ir_s[7:5];

  // Next-state, IR, PC and immediate update.
  always_comb begin
    estado_s = estado_r;
    ir_s     = ir_r;
    pc_s     = pc_r;
    imm_s    = imm_r;
    case (estado_r)
      INICIO: estado_s = BUSCA;
      BUSCA: begin
        if (MemValido) begin
          ir_s     = MemDado;
          pc_s     = pc_r + UM;
          estado_s = DECODIFICA;
        end else begin
          estado_s = BUSCA;
        end
      end
      DECODIFICA: begin
        case (opcode_s)
          OP_LDI:  estado_s = IMEDIATO;
          OP_JMP:  estado_s = IMEDIATO;
          OP_HALT: estado_s = PARADO;
          default: estado_s = EXECUTA;
        endcase
      end
      IMEDIATO: begin
        if (MemValido) begin
          if (opcode_s == OP_JMP) begin
            pc_s     = MemDado;
            estado_s = BUSCA;
          end else begin
            imm_s    = MemDado;
            pc_s     = pc_r + UM;
            estado_s = EXECUTA;
          end
        end else begin
          estado_s = IMEDIATO;
        end
      end
      EXECUTA: estado_s = BUSCA;
      PARADO:  estado_s = PARADO;
      default: estado_s = INICIO;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    memreq_s     = 1'b0;
    memend_s     = {LARGURA{1'b0}};
    regescrita_s = 1'b0;
    aluop_s      = 3'b000;
    selimm_s     = 1'b0;
    parado_s     = 1'b0;
    case (estado_s)
      BUSCA, IMEDIATO: begin
        memreq_s = 1'b1;
        memend_s = pc_s;
      end
      EXECUTA: begin
        regescrita_s = 1'b1;
        aluop_s      = opcode_nx_s;
        selimm_s     = (opcode_nx_s == OP_LDI);
      end
      PARADO:  parado_s = 1'b1;
      default: parado_s = 1'b0;
    endcase
  end

  // State and datapath-control registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado_r     <= INICIO;
      ir_r         <= {LARGURA{1'b0}};
      pc_r         <= PC_INICIAL;
      imm_r        <= {LARGURA{1'b0}};
      memreq_r     <= 1'b0;
      memend_r     <= {LARGURA{1'b0}};
      regescrita_r <= 1'b0;
      aluop_r      <= 3'b000;
      selimm_r     <= 1'b0;
      parado_r     <= 1'b0;
    end else begin
      estado_r     <= estado_s;
      ir_r         <= ir_s;
      pc_r         <= pc_s;
      imm_r        <= imm_s;
      memreq_r     <= memreq_s;
      memend_r     <= memend_s;
      regescrita_r <= regescrita_s;
      aluop_r      <= aluop_s;
      selimm_r     <= selimm_s;
      parado_r     <= parado_s;
    end
  end

  assign MemReq      = memreq_r;
  assign MemEndereco = memend_r;
  assign RegEscrita  = regescrita_r;
  assign RegDestino  = ir_r[4:3];
  assign RegFonteA   = ir_r[4:3];
  assign RegFonteB   = ir_r[2:1];
  assign AluOp       = aluop_r;
  assign SelImediato = selimm_r;
  assign Imediato    = imm_r;
  assign PC          = pc_r;
  assign Parado      = parado_r;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: behavioural memory plus a linear
// sequence of hand-computed checks.
module tb_unidade_controle;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       MemReq;
  logic [7:0] MemEndereco;
  logic       MemValido = 1'b0;
  logic [7:0] MemDado;
  logic       RegEscrita;
  logic [1:0] RegDestino;
  logic [1:0] RegFonteA;
  logic [1:0] RegFonteB;
  logic [2:0] AluOp;
  logic       SelImediato;
  logic [7:0] Imediato;
  logic [7:0] PC;
  logic       Parado;

  logic [7:0] mem [0:255];
  int vectors = 0;
  int miscompares = 0;
  int pulses;
  logic bad;

  assign MemDado = mem[MemEndereco];

  unidade_controle dut (
    .Clock(Clock), .Resetn(Resetn),
    .MemReq(MemReq), .MemEndereco(MemEndereco),
    .MemValido(MemValido), .MemDado(MemDado),
    .RegEscrita(RegEscrita), .RegDestino(RegDestino),
    .RegFonteA(RegFonteA), .RegFonteB(RegFonteB),
    .AluOp(AluOp), .SelImediato(SelImediato),
    .Imediato(Imediato), .PC(PC), .Parado(Parado)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset across two edges, release just after an edge: DUT sits in INICIO.
  task automatic pulse_reset();
    Resetn = 1'b0;
    step();
    step();
    Resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;

    // Reset state
    step();
    step();
    chk("rst_memreq", {7'd0, MemReq}, 8'h00);
    chk("rst_pc", PC, 8'h00);
    chk("rst_parado", {7'd0, Parado}, 8'h00);
    chk("rst_regescrita", {7'd0, RegEscrita}, 8'h00);
    chk("rst_memend", MemEndereco, 8'h00);

    // AND R1,R2 with zero-wait memory
    mem[8'h00] = 8'h8C;
    MemValido = 1'b1;
    Resetn = 1'b1;
    chk("inicio_memreq", {7'd0, MemReq}, 8'h00);
    pulses = 0;
    step();
    chk("busca_memreq", {7'd0, MemReq}, 8'h01);
    chk("busca_addr", MemEndereco, 8'h00);
    if (RegEscrita === 1'b1) pulses++;
    step();
    chk("dec_memreq", {7'd0, MemReq}, 8'h00);
    chk("dec_pc", PC, 8'h01);
    if (RegEscrita === 1'b1) pulses++;
    step();
    chk("and_regescrita", {7'd0, RegEscrita}, 8'h01);
    chk("and_rd", {6'd0, RegDestino}, 8'h01);
    chk("and_rsa", {6'd0, RegFonteA}, 8'h01);
    chk("and_rsb", {6'd0, RegFonteB}, 8'h02);
    chk("and_aluop", {5'd0, AluOp}, 8'h04);
    chk("and_selimm", {7'd0, SelImediato}, 8'h00);
    if (RegEscrita === 1'b1) pulses++;
    step();
    if (RegEscrita === 1'b1) pulses++;
    chk("and_pulses", pulses[7:0], 8'h01);
    chk("and_next_addr", MemEndereco, 8'h01);
    chk("and_next_aluop", {5'd0, AluOp}, 8'h00);

    // LDI R3,#5A with two wait cycles per read
    mem[8'h00] = 8'h18;
    mem[8'h01] = 8'h5A;
    MemValido = 1'b0;
    pulse_reset();
    step();
    step();
    chk("ldi_wait1_req", {7'd0, MemReq}, 8'h01);
    chk("ldi_wait1_addr", MemEndereco, 8'h00);
    step();
    chk("ldi_wait2_addr", MemEndereco, 8'h00);
    MemValido = 1'b1;
    step();
    MemValido = 1'b0;
    chk("ldi_dec_req", {7'd0, MemReq}, 8'h00);
    chk("ldi_dec_pc", PC, 8'h01);
    step();
    chk("ldi_imm_req", {7'd0, MemReq}, 8'h01);
    chk("ldi_imm_addr", MemEndereco, 8'h01);
    step();
    step();
    chk("ldi_immwait_req", {7'd0, MemReq}, 8'h01);
    chk("ldi_immwait_addr", MemEndereco, 8'h01);
    chk("ldi_immwait_we", {7'd0, RegEscrita}, 8'h00);
    MemValido = 1'b1;
    step();
    MemValido = 1'b0;
    chk("ldi_exe_we", {7'd0, RegEscrita}, 8'h01);
    chk("ldi_exe_selimm", {7'd0, SelImediato}, 8'h01);
    chk("ldi_exe_imm", Imediato, 8'h5A);
    chk("ldi_exe_rd", {6'd0, RegDestino}, 8'h03);
    chk("ldi_exe_aluop", {5'd0, AluOp}, 8'h00);
    chk("ldi_exe_pc", PC, 8'h02);
    step();
    chk("ldi_after_selimm", {7'd0, SelImediato}, 8'h00);
    chk("ldi_after_addr", MemEndereco, 8'h02);

    // JMP #F0 then AND at F0
    mem[8'h00] = 8'hC0;
    mem[8'h01] = 8'hF0;
    mem[8'hF0] = 8'h8C;
    MemValido = 1'b1;
    pulse_reset();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (RegEscrita !== 1'b0) bad = 1'b1;
    end
    chk("jmp_imm_addr", MemEndereco, 8'h01);
    step();
    if (RegEscrita !== 1'b0) bad = 1'b1;
    chk("jmp_no_write", {7'd0, bad}, 8'h00);
    chk("jmp_fetch_addr", MemEndereco, 8'hF0);
    chk("jmp_pc", PC, 8'hF0);
    step();
    chk("jmp_and_pc", PC, 8'hF1);
    step();
    chk("jmp_and_we", {7'd0, RegEscrita}, 8'h01);
    chk("jmp_and_aluop", {5'd0, AluOp}, 8'h04);

    // HALT
    mem[8'h00] = 8'hE0;
    pulse_reset();
    step();
    step();
    chk("halt_dec_parado", {7'd0, Parado}, 8'h00);
    step();
    chk("halt_parado", {7'd0, Parado}, 8'h01);
    chk("halt_memreq", {7'd0, MemReq}, 8'h00);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (MemReq !== 1'b0 || Parado !== 1'b1) bad = 1'b1;
    end
    chk("halt_hold", {7'd0, bad}, 8'h00);
    Resetn = 1'b0;
    #1;
    chk("halt_rst_parado", {7'd0, Parado}, 8'h00);
    chk("halt_rst_pc", PC, 8'h00);

    // LDI at FF, immediate wraps to 00; then reset mid-fetch
    mem[8'h00] = 8'hC0;
    mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h08;
    MemValido = 1'b1;
    pulse_reset();
    step();
    step();
    step();
    step();
    chk("wrap_fetch_addr", MemEndereco, 8'hFF);
    mem[8'h00] = 8'h77;
    step();
    chk("wrap_pc", PC, 8'h00);
    step();
    chk("wrap_imm_addr", MemEndereco, 8'h00);
    chk("wrap_imm_req", {7'd0, MemReq}, 8'h01);
    step();
    chk("wrap_imm", Imediato, 8'h77);
    chk("wrap_exe_pc", PC, 8'h01);
    chk("wrap_exe_rd", {6'd0, RegDestino}, 8'h01);
    chk("wrap_exe_selimm", {7'd0, SelImediato}, 8'h01);
    MemValido = 1'b0;
    step();
    chk("midrst_pre_req", {7'd0, MemReq}, 8'h01);
    chk("midrst_pre_addr", MemEndereco, 8'h01);
    #2;
    Resetn = 1'b0;
    #1;
    chk("midrst_req_async", {7'd0, MemReq}, 8'h00);
    chk("midrst_pc", PC, 8'h00);
    step();
    Resetn = 1'b1;
    step();
    chk("midrst_restart_req", {7'd0, MemReq}, 8'h01);
    chk("midrst_restart_addr", MemEndereco, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
